// File: rtl/rob.sv
// ---------------------------------------------------------------------------
// rob -- reorder buffer for an in-order-commit, out-of-order-complete core.
//
// Entries are allocated in program order at the tail, completed in any order
// by two result broadcast buses (ALU and load/store), and retired in program
// order from the head, at most one per cycle.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  global ready; low freezes all state and masks
//                           the pulse outputs
//   issue_*                 new instruction from the decoder
//   cdb_alu_*, cdb_lsb_*    result broadcasts (entry id, value, ALU next PC)
//   rob_full                decoder stall (asserted one slot early)
//   empty_rob_id            id the next issued instruction will receive
//   commit_*                register-file writeback for jalr / reg-writing
//   store_commit/_rob_id    release of the head store to the LSB
//   clear, corr_inst_addr   mispredict flush and redirect PC
// ---------------------------------------------------------------------------
module rob #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_ready,
  input  logic [31:0]          issue_inst_addr,
  input  logic [31:0]          issue_jump_addr,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd,
  input  logic                 cdb_alu_ready,
  input  logic [ROB_WIDTH-1:0] cdb_alu_id,
  input  logic [31:0]          cdb_alu_val,
  input  logic [31:0]          cdb_alu_addr,
  input  logic                 cdb_lsb_ready,
  input  logic [ROB_WIDTH-1:0] cdb_lsb_id,
  input  logic [31:0]          cdb_lsb_val,
  output logic                 rob_full,
  output logic [ROB_WIDTH-1:0] empty_rob_id,
  output logic                 commit_reg_en,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_val,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 store_commit,
  output logic [ROB_WIDTH-1:0] store_rob_id,
  output logic                 clear,
  output logic [31:0]          corr_inst_addr
);

  localparam int DEPTH = 1 << ROB_WIDTH;

  localparam logic [ROB_WIDTH:0]   CNT_FULL = (ROB_WIDTH+1)'(DEPTH);
  localparam logic [ROB_WIDTH:0]   CNT_NEAR = (ROB_WIDTH+1)'(DEPTH - 1);
  localparam logic [ROB_WIDTH:0]   CNT_ONE  = (ROB_WIDTH+1)'(1);
  localparam logic [ROB_WIDTH-1:0] PTR_ONE  = ROB_WIDTH'(1);

  localparam logic [1:0] TYPE_BRANCH = 2'b00;
  localparam logic [1:0] TYPE_STORE  = 2'b01;
  localparam logic [1:0] TYPE_JALR   = 2'b10;
  localparam logic [1:0] TYPE_REG    = 2'b11;

  // ---------------------------------------------------------------------
  // Pointer / occupancy state
  // ---------------------------------------------------------------------
  logic [ROB_WIDTH-1:0] head_reg, head_next;
  logic [ROB_WIDTH-1:0] tail_reg, tail_next;
  logic [ROB_WIDTH:0]   count_reg, count_next;

  // Registered pulse outputs and their payloads
  logic                 commit_reg_en_reg;
  logic [4:0]           commit_rd_reg;
  logic [31:0]          commit_val_reg;
  logic [ROB_WIDTH-1:0] commit_rob_id_reg;
  logic                 store_commit_reg;
  logic [ROB_WIDTH-1:0] store_rob_id_reg;
  logic                 clear_reg;
  logic [31:0]          corr_inst_addr_reg;

  // Flattened views of the per-entry storage, for the head read mux
  logic [DEPTH-1:0] ready_vec;
  logic [1:0]       type_mem [DEPTH];
  logic [4:0]       rd_mem   [DEPTH];
  logic [31:0]      val_mem  [DEPTH];
  logic [31:0]      addr_mem [DEPTH];
  logic [31:0]      jump_mem [DEPTH];

  logic        issue_fire;
  logic        commit_fire;
  logic        mispredict;
  logic [1:0]  head_type;
  logic        head_is_ctrl;
  logic        head_writes_reg;

  assign head_type       = type_mem[head_reg];
  assign head_is_ctrl    = (head_type == TYPE_BRANCH) || (head_type == TYPE_JALR);
  assign head_writes_reg = (head_type == TYPE_JALR) || (head_type == TYPE_REG);

  // Retire only when the head's ready bit is already registered, so a CDB
  // write retires no earlier than the cycle after it lands. Nothing
  // retires during the flush cycle.
  assign commit_fire = rdy_in && !clear_reg && (count_reg != '0) && ready_vec[head_reg];

  // A completely full buffer may still accept when the head retires in the
  // same cycle; otherwise an issue on a full buffer is dropped rather than
  // overwriting the oldest entry.
  assign issue_fire = rdy_in && issue_ready && !clear_reg &&
                      ((count_reg != CNT_FULL) || commit_fire);

  assign mispredict = commit_fire && head_is_ctrl &&
                      (addr_mem[head_reg] != jump_mem[head_reg]);

  // ---------------------------------------------------------------------
  // Per-entry storage
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [ROB_WIDTH-1:0] IDX = ROB_WIDTH'(gi);

      logic        entry_ready_reg;
      logic [1:0]  entry_type_reg;
      logic [4:0]  entry_rd_reg;
      logic [31:0] entry_val_reg;
      logic [31:0] entry_addr_reg;
      logic [31:0] entry_jump_reg;
      logic        issue_hit;
      logic        alu_hit;
      logic        lsb_hit;
      logic        retire_hit;

      assign issue_hit  = issue_fire && (tail_reg == IDX);
      assign alu_hit    = rdy_in && !clear_reg && cdb_alu_ready && (cdb_alu_id == IDX);
      assign lsb_hit    = rdy_in && !clear_reg && cdb_lsb_ready && (cdb_lsb_id == IDX);
      assign retire_hit = commit_fire && (head_reg == IDX);

      // Ready bit: a fresh allocation takes precedence over a stale
      // broadcast to the same slot; stores need no result so they are
      // complete as soon as they are allocated.
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          entry_ready_reg <= 1'b0;
        end else if (rdy_in) begin
          if (clear_reg) begin
            entry_ready_reg <= 1'b0;
          end else if (issue_hit) begin
            entry_ready_reg <= (issue_type == TYPE_STORE);
          end else if (alu_hit || lsb_hit) begin
            entry_ready_reg <= 1'b1;
          end else if (retire_hit) begin
            entry_ready_reg <= 1'b0;
          end
        end
      end

      // Payload is only consumed behind the ready bit, so it needs no reset.
      // The actual next PC defaults to the fall-through address until the
      // ALU reports the resolved target.
      always_ff @(posedge clk_in) begin
        if (issue_hit) begin
          entry_type_reg <= issue_type;
          entry_rd_reg   <= issue_rd;
          entry_jump_reg <= issue_jump_addr;
          entry_addr_reg <= issue_inst_addr + 32'd4;
          entry_val_reg  <= 32'd0;
        end else if (alu_hit) begin
          entry_val_reg  <= cdb_alu_val;
          entry_addr_reg <= cdb_alu_addr;
        end else if (lsb_hit) begin
          entry_val_reg  <= cdb_lsb_val;
        end
      end

      assign ready_vec[gi] = entry_ready_reg;
      assign type_mem[gi]  = entry_type_reg;
      assign rd_mem[gi]    = entry_rd_reg;
      assign val_mem[gi]   = entry_val_reg;
      assign addr_mem[gi]  = entry_addr_reg;
      assign jump_mem[gi]  = entry_jump_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Pointer next-state
  // ---------------------------------------------------------------------
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (clear_reg) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (commit_fire) head_next = head_reg + PTR_ONE;
      if (issue_fire)  tail_next = tail_reg + PTR_ONE;
      case ({issue_fire, commit_fire})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rdy_in) begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------------
  // Commit / flush outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      commit_reg_en_reg  <= 1'b0;
      commit_rd_reg      <= '0;
      commit_val_reg     <= '0;
      commit_rob_id_reg  <= '0;
      store_commit_reg   <= 1'b0;
      store_rob_id_reg   <= '0;
      clear_reg          <= 1'b0;
      corr_inst_addr_reg <= '0;
    end else if (rdy_in) begin
      commit_reg_en_reg <= commit_fire && head_writes_reg;
      store_commit_reg  <= commit_fire && (head_type == TYPE_STORE);
      clear_reg         <= mispredict;
      if (commit_fire) begin
        commit_rd_reg     <= rd_mem[head_reg];
        commit_val_reg    <= val_mem[head_reg];
        commit_rob_id_reg <= head_reg;
        if (head_type == TYPE_STORE) store_rob_id_reg <= head_reg;
      end
      if (mispredict) corr_inst_addr_reg <= addr_mem[head_reg];
    end
  end

  // While rdy_in is low the pulse registers hold, so a pulse pending across
  // a stall is presented exactly once, in the first cycle rdy_in returns.
  assign commit_reg_en  = commit_reg_en_reg & rdy_in;
  assign store_commit   = store_commit_reg & rdy_in;
  assign clear          = clear_reg & rdy_in;
  assign commit_rd      = commit_rd_reg;
  assign commit_val     = commit_val_reg;
  assign commit_rob_id  = commit_rob_id_reg;
  assign store_rob_id   = store_rob_id_reg;
  assign corr_inst_addr = corr_inst_addr_reg;

  // The decoder registers its issue, so stall one slot before truly full.
  assign rob_full     = (count_reg >= CNT_NEAR);
  assign empty_rob_id = tail_reg;

endmodule

// File: tb/tb_rob.sv
// ---------------------------------------------------------------------------
// tb_rob -- directed self-checking bench for rob (ROB_WIDTH = 3, 8 entries).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// so every check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_rob;
  localparam int W = 3;

  logic         clk_in = 1'b0;
  logic         rst_in, rdy_in, issue_ready;
  logic [31:0]  issue_inst_addr, issue_jump_addr;
  logic [1:0]   issue_type;
  logic [4:0]   issue_rd;
  logic         cdb_alu_ready, cdb_lsb_ready;
  logic [W-1:0] cdb_alu_id, cdb_lsb_id;
  logic [31:0]  cdb_alu_val, cdb_alu_addr, cdb_lsb_val;
  logic         rob_full, commit_reg_en, store_commit, clear;
  logic [W-1:0] empty_rob_id, commit_rob_id, store_rob_id;
  logic [4:0]   commit_rd;
  logic [31:0]  commit_val, corr_inst_addr;

  int tests = 0;
  int fails = 0;
  int n_commit = 0;

  rob #(.ROB_WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_ready(issue_ready), .issue_inst_addr(issue_inst_addr),
    .issue_jump_addr(issue_jump_addr), .issue_type(issue_type), .issue_rd(issue_rd),
    .cdb_alu_ready(cdb_alu_ready), .cdb_alu_id(cdb_alu_id),
    .cdb_alu_val(cdb_alu_val), .cdb_alu_addr(cdb_alu_addr),
    .cdb_lsb_ready(cdb_lsb_ready), .cdb_lsb_id(cdb_lsb_id), .cdb_lsb_val(cdb_lsb_val),
    .rob_full(rob_full), .empty_rob_id(empty_rob_id),
    .commit_reg_en(commit_reg_en), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id), .store_commit(store_commit),
    .store_rob_id(store_rob_id), .clear(clear), .corr_inst_addr(corr_inst_addr)
  );

  always #5 clk_in = ~clk_in;

  // Register-writeback pulses seen, for "nothing retires" checks.
  always @(negedge clk_in) if (commit_reg_en) n_commit <= n_commit + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    issue_ready   = 1'b0;
    cdb_alu_ready = 1'b0;
    cdb_lsb_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  task automatic issue1(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] jump);
    idle();
    issue_ready     = 1'b1;
    issue_type      = t;
    issue_rd        = rd;
    issue_jump_addr = jump;
    issue_inst_addr = jump - 32'd4;
    step();
    idle();
  endtask

  task automatic cdb_alu(input logic [W-1:0] id, input logic [31:0] val, input logic [31:0] addr);
    cdb_alu_ready = 1'b1;
    cdb_alu_id    = id;
    cdb_alu_val   = val;
    cdb_alu_addr  = addr;
  endtask

  task automatic cdb_lsb(input logic [W-1:0] id, input logic [31:0] val);
    cdb_lsb_ready = 1'b1;
    cdb_lsb_id    = id;
    cdb_lsb_val   = val;
  endtask

  localparam int N_WRAP = 22;

  initial begin
    int base;
    int nxt;
    rst_in = 1'b1; rdy_in = 1'b1; issue_ready = 1'b0;
    issue_inst_addr = '0; issue_jump_addr = '0; issue_type = '0; issue_rd = '0;
    cdb_alu_ready = 1'b0; cdb_alu_id = '0; cdb_alu_val = '0; cdb_alu_addr = '0;
    cdb_lsb_ready = 1'b0; cdb_lsb_id = '0; cdb_lsb_val = '0;

    // ---------------- reset state
    do_reset();
    check("rst rob_full",       32'(rob_full), 0);
    check("rst empty_rob_id",   32'(empty_rob_id), 0);
    check("rst commit_reg_en",  32'(commit_reg_en), 0);
    check("rst store_commit",   32'(store_commit), 0);
    check("rst clear",          32'(clear), 0);
    check("rst corr_inst_addr", corr_inst_addr, 0);

    // ---------------- out-of-order completion, in-order retire
    issue1(2'b11, 5'd1, 32'h10);
    issue1(2'b11, 5'd2, 32'h14);
    issue1(2'b11, 5'd3, 32'h18);
    check("ooo empty_rob_id", 32'(empty_rob_id), 3);
    cdb_alu(3'd2, 32'hAAAA_0001, 32'h0);
    cdb_lsb(3'd0, 32'hBBBB_0002);
    step(); idle();
    check("ooo no early commit", 32'(commit_reg_en), 0);
    cdb_alu(3'd1, 32'hCCCC_0003, 32'h0);
    step(); idle();
    check("ooo c0 en",  32'(commit_reg_en), 1);
    check("ooo c0 rd",  32'(commit_rd), 1);
    check("ooo c0 val", commit_val, 32'hBBBB_0002);
    check("ooo c0 id",  32'(commit_rob_id), 0);
    step();
    check("ooo c1 rd",  32'(commit_rd), 2);
    check("ooo c1 val", commit_val, 32'hCCCC_0003);
    check("ooo c1 id",  32'(commit_rob_id), 1);
    step();
    check("ooo c2 rd",  32'(commit_rd), 3);
    check("ooo c2 val", commit_val, 32'hAAAA_0001);
    check("ooo c2 id",  32'(commit_rob_id), 2);
    step();
    check("ooo drained en", 32'(commit_reg_en), 0);

    // ---------------- full threshold
    do_reset();
    for (int i = 0; i < 6; i++) issue1(2'b11, 5'(i + 1), 32'h100);
    check("full after 6", 32'(rob_full), 0);
    issue1(2'b11, 5'd7, 32'h100);
    check("full after 7",     32'(rob_full), 1);
    check("full empty_rob_id", 32'(empty_rob_id), 7);
    cdb_alu(3'd0, 32'h0000_00F0, 32'h0);
    step(); idle();
    check("full before commit", 32'(rob_full), 1);
    step();
    check("full commit en",  32'(commit_reg_en), 1);
    check("full after commit", 32'(rob_full), 0);

    // ---------------- branch mispredict flush
    do_reset();
    issue1(2'b00, 5'd0, 32'h100);
    issue1(2'b11, 5'd5, 32'h200);
    issue1(2'b11, 5'd6, 32'h300);
    cdb_alu(3'd0, 32'h0, 32'h104);
    cdb_lsb(3'd1, 32'h55);
    step(); idle();
    base = n_commit;
    cdb_alu(3'd2, 32'h66, 32'h0);
    step(); idle();
    check("mp clear",     32'(clear), 1);
    check("mp corr addr", corr_inst_addr, 32'h104);
    check("mp br no wb",  32'(commit_reg_en), 0);
    issue_ready = 1'b1; issue_type = 2'b11; issue_rd = 5'd9;
    step(); idle();
    check("mp clear one cycle", 32'(clear), 0);
    check("mp empty_rob_id",    32'(empty_rob_id), 0);
    check("mp not full",        32'(rob_full), 0);
    step(); step(); step();
    check("mp younger never commit", n_commit, base);

    // ---------------- store, jalr, correctly predicted branch
    do_reset();
    issue1(2'b01, 5'd0, 32'h40);
    check("st not yet", 32'(store_commit), 0);
    step();
    check("st commit",    32'(store_commit), 1);
    check("st rob id",    32'(store_rob_id), 0);
    check("st no reg wb", 32'(commit_reg_en), 0);
    step();
    check("st one cycle", 32'(store_commit), 0);
    issue1(2'b10, 5'd7, 32'h300);
    cdb_alu(3'd1, 32'h1234, 32'h300);
    step(); idle();
    step();
    check("jalr en",    32'(commit_reg_en), 1);
    check("jalr rd",    32'(commit_rd), 7);
    check("jalr val",   commit_val, 32'h1234);
    check("jalr clear", 32'(clear), 0);
    issue1(2'b00, 5'd0, 32'h200);
    cdb_alu(3'd2, 32'h0, 32'h200);
    step(); idle();
    step();
    check("br ok clear", 32'(clear), 0);
    check("br ok no wb", 32'(commit_reg_en), 0);
    step();
    check("br ok clear later", 32'(clear), 0);
    check("br ok empty_rob_id", 32'(empty_rob_id), 3);

    // ---------------- wrap-around with overlapping issue/retire and dual CDB
    do_reset();
    nxt = 0;
    for (int k = 0; k < N_WRAP + 6; k++) begin
      idle();
      if (k < N_WRAP) begin
        issue_ready = 1'b1; issue_type = 2'b11;
        issue_rd = 5'((k % 31) + 1);
        issue_jump_addr = 32'h1000 + 32'(4 * k);
        issue_inst_addr = issue_jump_addr - 32'd4;
      end
      if (k >= 2 && (k % 2) == 0) begin
        if (k - 2 < N_WRAP) cdb_alu(W'(k - 2), 32'hC0DE_0000 + 32'(k - 2), 32'h0);
        if (k - 1 < N_WRAP) cdb_lsb(W'(k - 1), 32'hC0DE_0000 + 32'(k - 1));
      end
      step(); idle();
      check($sformatf("wrap k%0d not full", k), 32'(rob_full), 0);
      if (commit_reg_en) begin
        check($sformatf("wrap c%0d id", nxt),  32'(commit_rob_id), 32'(nxt % 8));
        check($sformatf("wrap c%0d rd", nxt),  32'(commit_rd), 32'((nxt % 31) + 1));
        check($sformatf("wrap c%0d val", nxt), commit_val, 32'hC0DE_0000 + 32'(nxt));
        nxt++;
      end
    end
    check("wrap total commits", nxt, N_WRAP);
    check("wrap empty_rob_id", 32'(empty_rob_id), N_WRAP % 8);
    for (int i = 0; i < 6; i++) issue1(2'b11, 5'd1, 32'h0);
    check("wrap count 6 not full", 32'(rob_full), 0);
    issue1(2'b11, 5'd1, 32'h0);
    check("wrap count 7 full", 32'(rob_full), 1);

    // ---------------- rdy_in stall with pending CDB, then reset mid-stream
    do_reset();
    issue1(2'b11, 5'd9, 32'h40);
    cdb_alu(3'd0, 32'h77, 32'h0);
    issue_ready = 1'b1; issue_type = 2'b11; issue_rd = 5'd4;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d no commit", i), 32'(commit_reg_en), 0);
      check($sformatf("stall%0d tail held", i), 32'(empty_rob_id), 1);
    end
    issue_ready = 1'b0;
    rdy_in = 1'b1;
    step(); idle();
    check("stall cdb lands", 32'(commit_reg_en), 0);
    step();
    check("stall commit en",  32'(commit_reg_en), 1);
    check("stall commit val", commit_val, 32'h77);
    check("stall commit rd",  32'(commit_rd), 9);
    issue1(2'b11, 5'd1, 32'h0);
    issue1(2'b11, 5'd2, 32'h0);
    cdb_alu(3'd1, 32'h11, 32'h0);
    cdb_lsb(3'd2, 32'h22);
    step(); idle();
    base = n_commit;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("midrst commit_reg_en", 32'(commit_reg_en), 0);
    check("midrst empty_rob_id",  32'(empty_rob_id), 0);
    check("midrst rob_full",      32'(rob_full), 0);
    check("midrst store_commit",  32'(store_commit), 0);
    check("midrst clear",         32'(clear), 0);
    check("midrst corr addr",     corr_inst_addr, 0);
    step(); step(); step();
    check("midrst nothing retired", n_commit, base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 3, meaning log2 of entry count (DEPTH = 2^ROB_WIDTH = 8).
REQ-002 SHALL have clk_in  in  1  system clock, all state updates on rising edge.
REQ-003 SHALL have rst_in  in  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have rdy_in  in  1  global ready; low freezes all state.
REQ-005 SHALL have issue_ready  in  1  decoder issue strobe.
REQ-006 SHALL have issue_inst_addr  in  32  PC of issued instruction.
REQ-007 SHALL have issue_jump_addr  in  32  predicted next PC.
REQ-008 SHALL have issue_type  in  2  00 branch, 01 store, 10 jalr, 11 register-writing.
REQ-009 SHALL have issue_rd  in  5  destination register.
REQ-010 SHALL have cdb_alu_ready / cdb_lsb_ready  in  1 each  result broadcast strobes.
REQ-011 SHALL have cdb_alu_id / cdb_lsb_id  in  ROB_WIDTH each  target entry.
REQ-012 SHALL have cdb_alu_val / cdb_lsb_val  in  32 each  result value (rd data).
REQ-013 SHALL have cdb_alu_addr  in  32  actual next PC (branch/jalr only).
REQ-014 SHALL have rob_full  out  1  decoder stall.
REQ-015 SHALL have empty_rob_id  out  ROB_WIDTH  id the next issue receives.
REQ-016 SHALL have commit_reg_en  out  1, commit_rd  out  5, commit_val  out  32, commit_rob_id  out  ROB_WIDTH  regfile writeback.
REQ-017 SHALL have store_commit  out  1, store_rob_id  out  ROB_WIDTH  store release to LSB.
REQ-018 SHALL have clear  out  1, corr_inst_addr  out  32  mispredict flush and redirect PC.

Function
REQ-019 SHALL be a circular buffer: head (oldest), tail (next free), count 0..DEPTH; pointers wrap DEPTH-1 -> 0.
REQ-020 SHALL drive empty_rob_id = tail combinationally.
REQ-021 SHALL assert rob_full when count >= DEPTH-1 (one slot margin for the registered decoder issue).
REQ-022 SHALL accept an issue when rdy_in && issue_ready && !clear: write entry[tail], tail+1, ready bit = 1 for stores, 0 otherwise.
REQ-023 SHALL, on cdb_*_ready, store val (and addr for ALU) into the named entry and set its ready bit; both CDBs may write distinct entries in the same cycle.
REQ-024 SHALL commit at most one entry per cycle: entry[head] when count>0 and its ready bit was set before this edge (CDB write lands next cycle earliest).
REQ-025 SHALL on commit of type 11 or 10 pulse commit_reg_en one cycle with rd, val, rob_id of head; types 00/01 keep commit_reg_en low.
REQ-026 SHALL on commit of type 01 pulse store_commit one cycle with store_rob_id = head.
REQ-027 SHALL on commit of type 00/10 compare stored actual addr with issue_jump_addr; if unequal, pulse clear next cycle with corr_inst_addr = actual addr.
REQ-028 SHALL, in the clear cycle, discard everything: head=tail=count=0, all ready bits 0, ignore issue and CDB inputs.
REQ-029 SHALL handle issue and commit in the same cycle with count unchanged.
REQ-030 SHALL drive pulse outputs (commit_reg_en, store_commit, clear) low in any cycle rdy_in is low; state held.

Reset
REQ-031 SHALL on rst_in: head=tail=count=0, all ready bits 0, rob_full=0, empty_rob_id=0, commit_reg_en=0, store_commit=0, clear=0, corr_inst_addr=0; reset mid-operation discards all entries without commits.

Verification
REQ-032 Issue 3 type-11 (rd 1,2,3), CDB ids 2,0,1 vals A,B,C -> commits in order rd1=B, rd2=C, rd3=A, ids 0,1,2.
REQ-033 Issue 7 entries with no CDB -> rob_full=1 after 7th, empty_rob_id=7; one commit -> rob_full=0.
REQ-034 Branch jump_addr 0x100, CDB addr 0x104 -> one-cycle clear, corr_inst_addr=0x104, count=0, younger entries never commit.
REQ-035 Store at head -> store_commit=1, store_rob_id=head without any CDB; commit_reg_en=0.
REQ-036 Cycle 20+ entries through 8 slots with simultaneous issue/commit and dual CDB writes -> ids wrap 7->0, order preserved, count correct.
REQ-037 rdy_in low 3 cycles during pending CDB strobe and rst_in mid-stream -> no state change while low; after reset all outputs at reset values.
